// File: rtl/clk_rst_pkg.sv
// Shared types and default timing for the clock/reset manager.
// Imported by the manager top level and its channel dividers.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN
  } state_t;

  localparam int DEF_NUM_CE         = 2;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 1024;
  localparam int DEF_LOCK_STABLE    = 64;
  localparam int DEF_RST_HOLD       = 32;
  localparam int DEF_RETRY_W        = 4;

endpackage

// File: rtl/clk_rst_manager_if.sv
// PLL-side and core-side signal bundle of the clock/reset manager.
// The master modport is the manager; the slave side is PLL plus core.
interface clk_rst_manager_if #(
  parameter int NUM_CE  = 2,
  parameter int RETRY_W = 4
);

  logic               pll_lock;
  logic               clr_lost;
  logic               pll_resetb;
  logic               sys_rst_n;
  logic               ready;
  logic [NUM_CE-1:0]  ce;
  logic [RETRY_W-1:0] retry_cnt;
  logic               lock_lost;

  modport master (
    input  pll_lock,
    input  clr_lost,
    output pll_resetb,
    output sys_rst_n,
    output ready,
    output ce,
    output retry_cnt,
    output lock_lost
  );

  modport slave (
    output pll_lock,
    output clr_lost,
    input  pll_resetb,
    input  sys_rst_n,
    input  ready,
    input  ce,
    input  retry_cnt,
    input  lock_lost
  );

endinterface

// File: rtl/clk_rst_manager_ce_divider.sv
// One clock-enable channel: phase held at zero until run,
// then a single-cycle enable every div cycles.
module ce_divider #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic             ce
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || cnt == div - CNT_W'(1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign ce = run && (cnt == '0);

endmodule

// File: rtl/clk_rst_manager.sv
// PLL reset sequencing, lock qualification, core reset release
// and aligned clock-enable generation on the reference clock.
module clk_rst_manager
  import clk_rst_pkg::*;
#(
  parameter int NUM_CE         = DEF_NUM_CE,
  parameter int CNT_W          = DEF_CNT_W,
  parameter logic [NUM_CE*CNT_W-1:0] CE_DIV = {16'd4, 16'd2},
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int RST_HOLD       = DEF_RST_HOLD,
  parameter int RETRY_W        = DEF_RETRY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  clk_rst_manager_if.master  bus
);

  localparam logic [CNT_W-1:0] LIM_RST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM_TMO  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LIM_STB  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] LIM_HOLD = CNT_W'(RST_HOLD - 1);

  if (NUM_CE < 1 || NUM_CE > 8) begin : g_bad_num
    $error("NUM_CE must be 1..8");
  end
  if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
      LOCK_STABLE < 1 || RST_HOLD < 1) begin : g_bad_cyc
    $error("cycle parameters must be nonzero");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               sync1;
  logic               lock_s;
  logic               pll_resetb;
  logic               sys_rst_n;
  logic               ready;
  logic [RETRY_W-1:0] retry_cnt;
  logic               lock_lost;
  logic [NUM_CE-1:0]  ce;
  logic               run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= bus.pll_lock;
      lock_s <= sync1;
    end
  end

  // Outputs are written on the transition itself, so they follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PLL_RST;
      cnt        <= '0;
      pll_resetb <= 1'b0;
      sys_rst_n  <= 1'b0;
      ready      <= 1'b0;
      retry_cnt  <= '0;
      lock_lost  <= 1'b0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (bus.clr_lost) lock_lost <= 1'b0;
      unique case (state)
        PLL_RST: begin
          if (cnt == LIM_RST) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            pll_resetb <= 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == LIM_TMO) begin
            state      <= PLL_RST;
            cnt        <= '0;
            pll_resetb <= 1'b0;
            if (retry_cnt != '1) retry_cnt <= retry_cnt + RETRY_W'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == LIM_STB) begin
            state <= HOLD;
            cnt   <= '0;
          end
        end
        HOLD: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == LIM_HOLD) begin
            state     <= RUN;
            cnt       <= '0;
            sys_rst_n <= 1'b1;
            ready     <= 1'b1;
          end
        end
        RUN: begin
          cnt <= '0;
          if (!lock_s) begin
            state     <= WAIT_LOCK;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            lock_lost <= 1'b1;
          end
        end
        default: begin
          state      <= PLL_RST;
          cnt        <= '0;
          pll_resetb <= 1'b0;
          sys_rst_n  <= 1'b0;
          ready      <= 1'b0;
        end
      endcase
    end
  end

  assign run = (state == RUN);

  for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
    if (CE_DIV[i*CNT_W +: CNT_W] == '0) begin : g_bad_div
      $error("CE_DIV fields must be nonzero");
    end
    ce_divider #(
      .CNT_W (CNT_W)
    ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .div   (CE_DIV[i*CNT_W +: CNT_W]),
      .ce    (ce[i])
    );
  end

  assign bus.pll_resetb = pll_resetb;
  assign bus.sys_rst_n  = sys_rst_n;
  assign bus.ready      = ready;
  assign bus.ce         = ce;
  assign bus.retry_cnt  = retry_cnt;
  assign bus.lock_lost  = lock_lost;

endmodule

// File: tb/tb_clk_rst_manager.sv
// Scoreboard bench: the stimulus pushes a per-cycle expected output
// vector from a phase timeline; a monitor pops and compares each cycle.
module tb_clk_rst_manager;

  localparam int NCE  = 2;
  localparam int CW   = 16;
  localparam int DIV0 = 2;
  localparam int DIV1 = 4;
  localparam int TMO  = 32;
  localparam int RW   = 4;

  localparam int S_RST  = 0;
  localparam int S_WAIT = 1;
  localparam int S_STAB = 2;
  localparam int S_HOLD = 3;
  localparam int S_RUN  = 4;

  typedef struct packed {
    logic          pr;
    logic          sr;
    logic          rd;
    logic [1:0]    ce;
    logic [RW-1:0] rc;
    logic          ll;
  } vec_t;

  typedef struct {
    int   cyc;
    vec_t v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_rst_manager_if #(.NUM_CE(NCE), .RETRY_W(RW)) bus ();

  clk_rst_manager #(
    .NUM_CE         (NCE),
    .CNT_W          (CW),
    .CE_DIV         ({16'(DIV1), 16'(DIV0)}),
    .PLL_RST_CYCLES (16),
    .LOCK_TIMEOUT   (TMO),
    .LOCK_STABLE    (64),
    .RST_HOLD       (32),
    .RETRY_W        (RW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t q[$];
  vec_t aq[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc;
  int   m_cyc, m_retry, m_run;
  logic m_lost;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic vec_t sample();
    return {bus.pll_resetb, bus.sys_rst_n, bus.ready,
            bus.ce, bus.retry_cnt, bus.lock_lost};
  endfunction

  // n cycles spent in state st, in the terms the outputs are defined by
  task automatic push(input int st, input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.cyc   = m_cyc;
      e.v.pr  = (st != S_RST);
      e.v.sr  = (st == S_RUN);
      e.v.rd  = (st == S_RUN);
      e.v.ce[0] = (st == S_RUN) && (m_run % DIV0 == 0);
      e.v.ce[1] = (st == S_RUN) && (m_run % DIV1 == 0);
      e.v.rc  = RW'(m_retry);
      e.v.ll  = m_lost;
      q.push_back(e);
      m_cyc++;
      m_run = (st == S_RUN) ? m_run + 1 : 0;
    end
  endtask

  task automatic model_reset();
    m_cyc   = 0;
    m_retry = 0;
    m_run   = 0;
    m_lost  = 1'b0;
  endtask

  task automatic at_edge(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      vec_t a;
      e = q.pop_front();
      a = sample();
      n_chk++;
      if (a === e.v) n_pass++;
      else $display("FAIL outputs cyc=%0d got=%b want=%b", e.cyc, a, e.v);
    end
  end

  always @(negedge rst_n) begin
    if (aq.size() > 0) begin
      vec_t w;
      vec_t a;
      #1;
      w = aq.pop_front();
      a = sample();
      n_chk++;
      if (a === w) n_pass++;
      else $display("FAIL async_reset got=%b want=%b", a, w);
    end
  end

  initial begin
    int g, r1, w, r2, d, r3;
    int s1, k, st, s2, p;
    g  = $urandom_range(5, 60);
    r1 = $urandom_range(4, 30);
    w  = $urandom_range(4, 20);
    r2 = $urandom_range(4, 30);
    d  = $urandom_range(3, 20);
    r3 = $urandom_range(4, 30);
    bus.pll_lock = 1'b1;
    bus.clr_lost = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    model_reset();
    push(S_RST, 16);
    push(S_WAIT, 1);
    push(S_STAB, g + 1);
    push(S_WAIT, 1);
    push(S_STAB, 64);
    push(S_HOLD, 32);
    s1 = m_cyc;
    push(S_RUN, r1);
    m_lost = 1'b1;
    push(S_WAIT, w);
    st = m_cyc;
    push(S_STAB, 6);
    m_lost = 1'b0;
    push(S_STAB, 58);
    push(S_HOLD, 32);
    s2 = m_cyc;
    push(S_RUN, r2);

    at_edge(15 + g);
    bus.pll_lock = 1'b0;
    at_edge(16 + g);
    bus.pll_lock = 1'b1;
    k = s1 + r1 - 3;
    at_edge(k);
    bus.pll_lock = 1'b0;
    at_edge(k + 2);
    bus.clr_lost = 1'b1;
    at_edge(k + 3);
    bus.clr_lost = 1'b0;
    at_edge(k + w);
    bus.pll_lock = 1'b1;
    at_edge(st + 5);
    bus.clr_lost = 1'b1;
    at_edge(st + 6);
    bus.clr_lost = 1'b0;

    at_edge(s2 + r2);
    aq.push_back('0);
    bus.pll_lock = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;

    model_reset();
    for (int a = 0; a < 17; a++) begin
      push(S_RST, 16);
      push(S_WAIT, TMO);
      m_retry = (m_retry < 15) ? m_retry + 1 : 15;
    end
    p = m_cyc;
    push(S_RST, 16);
    push(S_WAIT, d);
    push(S_STAB, 64);
    push(S_HOLD, 32);
    push(S_RUN, r3);

    at_edge(p + 13 + d);
    bus.pll_lock = 1'b1;

    for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    #20;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
